// File: rtl/uart_prog_pkg.sv
// Shared constants, state encoding and checksum helper for the UART program loader.
// Marker constants hold the oldest received byte in bits [31:24].
package uart_prog_pkg;

   localparam logic [31:0] START_MARK = 32'h5aa5_0ff0;
   localparam logic [31:0] END_MARK   = 32'hf00f_a55a;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_TMO  = 2'd2;
   localparam logic [1:0] ERR_CSUM = 2'd3;

   function automatic logic [7:0] word_sum(input logic [31:0] w);
      return w[7:0] + w[15:8] + w[23:16] + w[31:24];
   endfunction

endpackage

// File: rtl/uart_prog_loader_marker_match.sv
// Four-byte sliding window over the byte stream with start/end marker comparators.
// Hits are evaluated on the window as it will look once the current byte is shifted in.
module prog_marker_match
   import uart_prog_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  data,
   output logic        start_hit,
   output logic        end_hit,
   output logic [31:0] window_next
);

   logic [31:0] window_r;

   // look-ahead window and marker compare
   always_comb begin
      window_next = {window_r[23:0], data};
      start_hit   = shift && (window_next == START_MARK);
      end_hit     = shift && (window_next == END_MARK);
   end

   // window register
   always_ff @(posedge clk) begin
      if (reset) begin
         window_r <= 32'h0000_0000;
      end else if (clear) begin
         window_r <= 32'h0000_0000;
      end else if (shift) begin
         window_r <= window_next;
      end else begin
         window_r <= window_r;
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Stream-side program loader: hunts the start marker, packs payload little-endian into
// words written to instruction memory, and finishes on a word-aligned end marker.
module uart_prog_loader
   import uart_prog_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_0000),
   parameter int                DEPTH_WORDS = 1024,
   parameter int                TIMEOUT_CYC = 500000,
   parameter int                CHECKSUM_EN = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 rx_valid,
   input  logic [7:0]                           rx_data,
   output logic                                 mem_we,
   output logic [ADDR_W-1:0]                    mem_addr,
   output logic [31:0]                          mem_wdata,
   output logic                                 prog_busy,
   output logic                                 load_done,
   output logic                                 load_err,
   output logic [1:0]                           err_code,
   output logic [$clog2(DEPTH_WORDS+1)-1:0]     word_count
);

   localparam int CW = $clog2(DEPTH_WORDS + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 2);
   localparam logic [CW-1:0] DEPTH_LIM = CW'(DEPTH_WORDS);
   localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_CYC);

   state_t        state_r, state_next_s;
   logic [1:0]    byte_idx_r;
   logic [7:0]    checksum_r;
   logic [TW-1:0] tmo_cnt_r;
   logic          start_hit_s, end_hit_s, shift_s, clear_s;
   logic [31:0]   window_next_s, word_s;
   logic          last_byte_s, full_s, tmo_s;
   logic          we_s, start_s, done_s, err_set_s;
   logic [1:0]    err_val_s;

   assign shift_s     = rx_valid && ((state_r == IDLE) || (state_r == RECV));
   assign clear_s     = (state_r == DONE) || (state_r == ERR);
   assign last_byte_s = (state_r == RECV) && rx_valid && (byte_idx_r == 2'd3);
   assign full_s      = (word_count == DEPTH_LIM);
   // the cycle after a byte the counter reads 1, so expiry lands TIMEOUT_CYC cycles after it
   assign tmo_s       = (TIMEOUT_CYC != 32'sd0) && !rx_valid && (tmo_cnt_r >= TMO_LIM - TW'(1'b1));
   // window holds the oldest byte high; the memory word wants it low
   assign word_s      = {window_next_s[7:0], window_next_s[15:8],
                         window_next_s[23:16], window_next_s[31:24]};

   prog_marker_match u_match (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear_s),
      .shift       (shift_s),
      .data        (rx_data),
      .start_hit   (start_hit_s),
      .end_hit     (end_hit_s),
      .window_next (window_next_s)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_hit_s) state_next_s = RECV;
            else             state_next_s = IDLE;
         end
         RECV: begin
            if (last_byte_s && end_hit_s) state_next_s = (CHECKSUM_EN != 32'sd0) ? CHECK : DONE;
            else if (last_byte_s && full_s) state_next_s = ERR;
            else if (tmo_s)                 state_next_s = ERR;
            else                            state_next_s = RECV;
         end
         CHECK: begin
            if (rx_valid)   state_next_s = (rx_data == checksum_r) ? DONE : ERR;
            else if (tmo_s) state_next_s = ERR;
            else            state_next_s = CHECK;
         end
         DONE:    state_next_s = IDLE;
         ERR:     state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // output decode feeding the registered outputs
   always_comb begin
      we_s      = 1'b0;
      start_s   = 1'b0;
      err_val_s = ERR_NONE;
      case (state_r)
         IDLE: start_s = start_hit_s;
         RECV: begin
            we_s = last_byte_s && !end_hit_s && !full_s;
            if (rx_valid) err_val_s = ERR_OVF;
            else          err_val_s = ERR_TMO;
         end
         CHECK: begin
            if (rx_valid) err_val_s = ERR_CSUM;
            else          err_val_s = ERR_TMO;
         end
         default: begin
            we_s    = 1'b0;
            start_s = 1'b0;
         end
      endcase
      done_s    = (state_next_s == DONE);
      err_set_s = (state_next_s == ERR);
   end

   // datapath, counters and sticky status
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we     <= 1'b0;
         mem_addr   <= {ADDR_W{1'b0}};
         mem_wdata  <= 32'h0000_0000;
         prog_busy  <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         err_code   <= ERR_NONE;
         word_count <= {CW{1'b0}};
         byte_idx_r <= 2'd0;
         checksum_r <= 8'h00;
         tmo_cnt_r  <= {TW{1'b0}};
      end else begin
         mem_we    <= we_s;
         load_done <= done_s;
         prog_busy <= (state_next_s == RECV) || (state_next_s == CHECK);
         if (we_s) begin
            mem_addr  <= BASE_ADDR + (ADDR_W'(word_count) << 2);
            mem_wdata <= word_s;
         end
         if (start_s) begin
            word_count <= {CW{1'b0}};
            byte_idx_r <= 2'd0;
            checksum_r <= 8'h00;
            load_err   <= 1'b0;
            err_code   <= ERR_NONE;
         end else begin
            if (we_s) begin
               word_count <= word_count + CW'(1'b1);
               checksum_r <= checksum_r + word_sum(word_s);
            end
            if ((state_r == RECV) && rx_valid) byte_idx_r <= byte_idx_r + 2'd1;
            if (err_set_s) begin
               load_err <= 1'b1;
               err_code <= err_val_s;
            end
         end
         if (rx_valid)                                      tmo_cnt_r <= TW'(1'b1);
         else if ((state_r == RECV) || (state_r == CHECK))  tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
         else                                               tmo_cnt_r <= {TW{1'b0}};
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench: table-driven byte streams with a reference packer feeding a
// write scoreboard, plus hand sequences for timeout, byte-wins boundary and reset mid-load.
module tb_uart_prog_loader;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        prog_busy;
   logic        load_done;
   logic        load_err;
   logic [1:0]  err_code;
   logic [2:0]  word_count;

   int vectors = 0;
   int miscompares = 0;
   logic saw_done;
   logic [63:0] exp_q[$];

   // reference packer state
   int          m_mode;
   logic [31:0] m_win;
   logic [31:0] m_word;
   int          m_idx;
   int          m_wc;

   typedef struct packed {
      logic [191:0] bytes;
      logic [7:0]   n;
      logic         done;
      logic         err;
      logic [1:0]   code;
      logic [2:0]   wc;
   } vec_t;

   vec_t tbl[7];

   uart_prog_loader #(
      .ADDR_W      (32),
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .TIMEOUT_CYC (100),
      .CHECKSUM_EN (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .prog_busy  (prog_busy),
      .load_done  (load_done),
      .load_err   (load_err),
      .err_code   (err_code),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [191:0] s, input int n, input logic d, input logic e,
                               input logic [1:0] c, input logic [2:0] w);
      vec_t v;
      v.bytes = s << (8 * (24 - n));
      v.n     = 8'(n);
      v.done  = d;
      v.err   = e;
      v.code  = c;
      v.wc    = w;
      return v;
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_win  = 32'h0;
      m_idx  = 0;
   endtask

   task automatic model_step(input logic [7:0] b);
      case (m_mode)
         0: begin
            m_win = {m_win[23:0], b};
            if (m_win == 32'h5aa5_0ff0) begin
               m_mode = 1; m_idx = 0; m_wc = 0;
            end
         end
         1: begin
            m_word[m_idx*8 +: 8] = b;
            m_idx++;
            if (m_idx == 4) begin
               m_idx = 0;
               // f0 0f a5 5a packed little-endian
               if (m_word == 32'h5aa5_0ff0) m_mode = 2;
               else if (m_wc == DEPTH) model_reset();
               else begin
                  exp_q.push_back({BASE + 32'(m_wc * 4), m_word});
                  m_wc++;
               end
            end
         end
         default: model_reset();
      endcase
   endtask

   // drive one byte for one cycle; called and returns at a falling edge
   task automatic send_byte(input logic [7:0] b);
      model_step(b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_stream(input logic [191:0] s, input int n);
      logic [191:0] t;
      t = s << (8 * (24 - n));
      for (int i = 0; i < n; i++) begin
         send_byte(t[191 - 8*i -: 8]);
         @(negedge clk);
      end
   endtask

   // write scoreboard and done-pulse monitor
   always @(negedge clk) begin
      logic [63:0] e;
      if (load_done === 1'b1) saw_done = 1'b1;
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
            check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
         end
      end
   end

   initial begin
      tbl[0] = mk(136'h5aa50ff0_10203040_50607080_f00fa55a_40, 17, 1'b1, 1'b0, 2'd0, 3'd2);
      tbl[1] = mk(136'h5aa50ff0_10203040_50607080_f00fa55a_41, 17, 1'b0, 1'b1, 2'd3, 3'd2);
      tbl[2] = mk(136'h5aa50ff0_00f00fa5_5a000000_f00fa55a_fe, 17, 1'b1, 1'b0, 2'd0, 3'd2);
      tbl[3] = mk(192'h5aa50ff0_04030201_08070605_0c0b0a09_100f0e0d_14131211, 24, 1'b0, 1'b1, 2'd1, 3'd4);
      tbl[4] = mk(112'h5a5aa50ff0_11223344_f00fa55a_aa, 14, 1'b1, 1'b0, 2'd0, 3'd1);
      tbl[5] = mk(72'h5aa50ff0_f00fa55a_00, 9, 1'b1, 1'b0, 2'd0, 3'd0);
      tbl[6] = mk(112'haa5aa50ff0_deadbeef_f00fa55a_38, 14, 1'b1, 1'b0, 2'd0, 3'd1);

      saw_done = 1'b0;
      model_reset();
      m_wc     = 0;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_busy", 64'(prog_busy), 64'd0);
      check("rst_done", 64'(load_done), 64'd0);
      check("rst_err", 64'(load_err), 64'd0);
      check("rst_code", 64'(err_code), 64'd0);
      check("rst_wc", 64'(word_count), 64'd0);

      for (int v = 0; v < 7; v++) begin
         saw_done = 1'b0;
         send_stream(tbl[v].bytes >> (8 * (24 - int'(tbl[v].n))), int'(tbl[v].n));
         repeat (6) @(negedge clk);
         check($sformatf("v%0d_done", v), 64'(saw_done), 64'(tbl[v].done));
         check($sformatf("v%0d_err", v), 64'(load_err), 64'(tbl[v].err));
         check($sformatf("v%0d_code", v), 64'(err_code), 64'(tbl[v].code));
         check($sformatf("v%0d_wc", v), 64'(word_count), 64'(tbl[v].wc));
         check($sformatf("v%0d_busy", v), 64'(prog_busy), 64'd0);
      end

      // timeout boundary: a byte in the expiry cycle wins, then a real timeout
      saw_done = 1'b0;
      send_stream(32'h5aa50ff0, 4);
      send_byte(8'haa);
      @(negedge clk);
      send_byte(8'hbb);
      repeat (98) @(negedge clk);
      send_byte(8'hcc);
      check("tmo_byte_wins_err", 64'(load_err), 64'd0);
      check("tmo_byte_wins_busy", 64'(prog_busy), 64'd1);
      repeat (98) @(negedge clk);
      check("tmo_early_err", 64'(load_err), 64'd0);
      check("tmo_early_busy", 64'(prog_busy), 64'd1);
      @(negedge clk);
      check("tmo_err", 64'(load_err), 64'd1);
      check("tmo_code", 64'(err_code), 64'd2);
      check("tmo_busy", 64'(prog_busy), 64'd0);
      check("tmo_wc", 64'(word_count), 64'd0);
      model_reset();
      repeat (4) @(negedge clk);

      // reset after the first payload word is written
      send_stream(64'h5aa50ff0_11223344, 8);
      check("rml_busy_before", 64'(prog_busy), 64'd1);
      check("rml_wc_before", 64'(word_count), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rml_busy", 64'(prog_busy), 64'd0);
      check("rml_wc", 64'(word_count), 64'd0);
      model_reset();
      send_stream(72'h55667788_f00fa55a_00, 9);
      repeat (4) @(negedge clk);
      check("rml_busy_after", 64'(prog_busy), 64'd0);
      check("rml_no_done", 64'(saw_done), 64'd0);

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Stream-side program loader between the SoC UART receiver and the instruction memory write port.
- Hunts for the start marker 5a a5 0f f0, then packs payload bytes little-endian into 32-bit words and writes them to consecutive word addresses.
- Stops on the end marker f0 0f a5 5a, which is recognised only on a word boundary.
- Successor to the fixed loader: parametrised base/depth, overflow protection, inter-byte timeout, optional checksum byte, sticky status and a CPU hold output.

Parameters:
- ADDR_W, 32, memory byte-address width.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- DEPTH_WORDS, 1024, maximum payload words accepted.
- TIMEOUT_CYC, 500000, maximum clk cycles between bytes while loading; 0 disables the timeout.
- CHECKSUM_EN, 1, when 1 one checksum byte follows the end marker.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- mem_we  out  1  one-cycle instruction memory write strobe.
- mem_addr  out  ADDR_W  byte address: BASE_ADDR + 4*n.
- mem_wdata  out  32  packed word; first received byte in bits [7:0].
- prog_busy  out  1  high from start-marker detection until DONE/ERR; holds the core in reset.
- load_done  out  1  one-cycle pulse at the end of a successful load.
- load_err  out  1  sticky error flag; cleared at the next start-marker detection.
- err_code  out  2  sticky error code: 0 none, 1 overflow, 2 timeout, 3 checksum.
- word_count  out  clog2(DEPTH_WORDS+1)  words written in the current or last load.

Behaviour:
- Reset (synchronous, active-high) clears all outputs, the state, counters, the byte window and the checksum. State -> IDLE. Reset mid-load abandons the load; no further writes occur.
- IDLE:
  - Shifts every byte into a 4-byte sliding window.
  - A window equal to 5a a5 0f f0 (oldest byte first) -> RECV on the next cycle. Overlapping matches count, e.g. 5a 5a a5 0f f0 is detected.
  - On detection: prog_busy=1, word_count=0, byte index=0, checksum=0, load_err=0, err_code=0.
- RECV:
  - Each byte is placed at lane = byte index; the byte index wraps 3->0.
  - When the 4th byte of a word arrives:
    - Assembled byte sequence equals f0 0f a5 5a -> no write. Go to CHECK if CHECKSUM_EN, else DONE.
    - Otherwise, if word_count==DEPTH_WORDS -> ERR with code 1, no write.
    - Otherwise the cycle after that byte: mem_we=1, mem_addr=BASE_ADDR+4*word_count, mem_wdata=word; word_count increments in the same cycle. Write latency is one cycle.
  - Checksum = 8-bit sum mod 256 of non-marker payload bytes only, added as each word is committed.
  - The end marker straddling word boundaries is payload, not end.
- CHECK: the next byte is compared to the checksum. Equal -> DONE, else ERR code 3.
- Timeout (RECV and CHECK only):
  - Counter reset on every rx_valid. Reaching TIMEOUT_CYC -> ERR code 2.
  - rx_valid in the same cycle the counter expires: the byte wins, no timeout.
- DONE: load_done=1 for one cycle, prog_busy=0 -> IDLE.
- ERR: load_err=1, err_code set (both held until the next start), prog_busy=0 -> IDLE.
- Bytes arriving in DONE/ERR are ignored; the IDLE window is cleared on entry to IDLE.
- Words already written before an error remain written. word_count holds its value until the next start.

Decomposition:
- Package uart_prog_pkg: START_MARK and END_MARK 32-bit constants (byte order defined), state enum {IDLE, RECV, CHECK, DONE, ERR}, err_code constants.
- One sub-module, prog_marker_match: 4-byte shift window plus comparator. Used in IDLE for sliding start detection; a word-aligned compare is used in RECV.

Test Plan:
- 5a a5 0f f0, 10 20 30 40 50 60 70 80, f0 0f a5 5a, 40 (CHECKSUM_EN=1) -> writes 0x40302010 @BASE, then 0x80706050 @BASE+4; load_done pulse; word_count=2; load_err=0.
- Same stream with checksum byte 41 -> two writes, then load_err=1, err_code=3, no load_done.
- DEPTH_WORDS=1, two payload words -> one write @BASE, then ERR code 1 on the 2nd word, no 2nd write.
- TIMEOUT_CYC=100: start marker + 2 payload bytes, then idle -> ERR code 2 exactly 100 cycles after the last byte, prog_busy falls, no write.
- Payload 00 f0 0f a5 5a 00 00 00 (marker unaligned), then aligned end marker -> writes 0xa50ff000 and 0x0000005a; load completes normally.
- Reset asserted after the first payload word is written -> next cycle prog_busy=0, state IDLE; subsequent payload bytes cause no writes until a new start marker.
